track_sensor_conditioner: RTL
=============================

// Module: track_sensor_conditioner
// PURPOSE
//  Upstream front end for the train-control state machine. Takes the four raw, asynchronous
//  track-sensor contacts and synchronises and debounces each one. Drives the clean SR[4:1]
//  levels that the controller's next-state logic consumes.
//  Also gives one-cycle rising-edge pulses and a latched stuck-sensor fault per sensor.
// PARAMETERS
//  DEBOUNCE_CYCLES  4     consecutive agreeing synced samples needed to change SR[i] (>=1)
//  CNT_W            3     debounce counter width; must hold DEBOUNCE_CYCLES-1
//  STUCK_CYCLES     1000  consecutive cycles of SR[i]=1 before STUCK[i] sets (>=1)
//  STUCK_W          10    stuck counter width; must hold STUCK_CYCLES-1
// PORTS
//  Clock      in   1  single system clock, all state on rising edge
//  RESET      in   1  synchronous, active-high reset
//  RAW_SR     in   4  [4:1] raw sensor contacts, asynchronous to Clock, may bounce
//  CLR_STUCK  in   1  one-cycle request to clear all STUCK bits and stuck counters
//  SR         out  4  [4:1] debounced sensor levels, registered
//  SR_RISE    out  4  [4:1] one-cycle pulse, high in the same cycle SR[i] goes 0->1
//  STUCK      out  4  [4:1] latched fault: SR[i] has been high for STUCK_CYCLES cycles
//  FAULT      out  1  |STUCK, registered alongside STUCK
// BEHAVIOUR
//  Reset:
//  - RESET=1 at an edge clears the sync flops, debounce counters, stuck counters,
//    SR, SR_RISE, STUCK and FAULT to 0.
//  - RESET has priority over every other input. A debounce in progress is discarded.
//  Synchroniser:
//  - Two flops per bit: s1<=RAW_SR[i], s2<=s1.
//  - Only s2 is used downstream.
//  Debounce (per bit i, state: SR[i], cnt[i]):
//  - s2==SR[i]: cnt<=0.
//  - s2!=SR[i] and cnt==DEBOUNCE_CYCLES-1: SR[i]<=s2, cnt<=0.
//  - s2!=SR[i] otherwise: cnt<=cnt+1.
//  - Any single disagreeing-to-agreeing sample restarts the count. Glitches shorter than
//    DEBOUNCE_CYCLES synced cycles never reach SR.
//  - Latency: the raw edge is first captured by s1 at edge #1. SR[i] changes at edge
//    #(DEBOUNCE_CYCLES+2), which is #6 at the default.
//  Rise pulse:
//  - SR_RISE[i]<=1 at the edge where SR[i] goes 0->1, and is 0 at every other edge.
//  - Exactly one cycle wide. A falling SR gives no pulse.
//  Stuck watchdog (per bit i, state: scnt[i], STUCK[i]):
//  - SR[i]==0: scnt<=0. STUCK holds.
//  - SR[i]==1 and scnt<STUCK_CYCLES-1: scnt<=scnt+1.
//  - SR[i]==1 and scnt==STUCK_CYCLES-1: STUCK[i]<=1, scnt holds (saturates).
//  - If SR rises at edge E, STUCK[i] sets at edge E+STUCK_CYCLES.
//  - STUCK[i] stays set if SR[i] later falls. It clears only on RESET or CLR_STUCK.
//  - CLR_STUCK=1 at an edge sets all STUCK<=0 and scnt<=0, and this wins over a
//    same-edge set. Counting resumes next edge.
//  - FAULT follows STUCK with the same registered timing.
//  Sensor independence:
//  - All four bits are independent. Simultaneous changes on several bits are each
//    handled per bit, with no cross-coupling.
// TESTING
//  Defaults unless stated. Bench override for stuck tests: STUCK_CYCLES=20, STUCK_W=5.
//  1 Reset: RESET=1 for 2 cycles with RAW_SR=4'b1111 -> SR=0, SR_RISE=0, STUCK=0, FAULT=0
//    during reset. SR=4'b1111 at the 6th edge after release.
//  2 Clean rise: RAW_SR 0000->0001, held -> SR[1]=1 at edge #6. SR_RISE=4'b0001 for
//    exactly that one cycle. SR[4:2] stay 0.
//  3 Bounce: RAW_SR[2] synced pattern 1,1,1,0,1,1,1,1 -> SR[2] stays 0 through the first
//    run. SR[2] rises 4 edges after the final run starts.
//  4 Fall: SR=4'b0100 settled, RAW_SR[3]->0 -> SR[3]=0 at edge #6. SR_RISE stays 0000.
//  5 Stuck: RAW_SR[4] held high -> STUCK[4]=1 and FAULT=1 exactly 20 edges after SR[4]
//    rose. CLR_STUCK pulse -> both 0 next edge, reassert 20 edges later while still high.
//  6 Reset mid-debounce: RAW_SR[1] 0->1, RESET=1 at edge #4 for 1 cycle -> SR[1] stays 0.
//    It rises 6 edges after release with no early change.

Source files
------------

// File: rtl/track_sensor_conditioner.sv
// track_sensor_conditioner
// Front end for the train-control sequencer. Each of the four raw track-sensor
// contacts is brought into the Clock domain through two flops and then debounced.
// The block drives the clean SR[4:1] levels, a one-cycle pulse on each 0->1
// transition, and a latched stuck-sensor fault for each bit.
// All bits are handled independently. There is no cross-coupling between sensors.

module track_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,     // agreeing synced samples needed to move SR
    parameter int CNT_W           = 3,     // must hold DEBOUNCE_CYCLES-1
    parameter int STUCK_CYCLES    = 1000,  // cycles of SR=1 before STUCK sets
    parameter int STUCK_W         = 10     // must hold STUCK_CYCLES-1
) (
    input  logic        Clock,
    input  logic        RESET,
    input  logic [4:1]  RAW_SR,
    input  logic        CLR_STUCK,
    output logic [4:1]  SR,
    output logic [4:1]  SR_RISE,
    output logic [4:1]  STUCK,
    output logic        FAULT
);

    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [STUCK_W-1:0] SCNT_MAX = STUCK_W'(STUCK_CYCLES - 1);

    // Synchroniser stages. Only s2 is used past this point.
    logic [4:1] s1;
    logic [4:1] s2;

    // Per-bit debounce and stuck-watchdog counters.
    logic [4:1][CNT_W-1:0]   cnt;
    logic [4:1][STUCK_W-1:0] scnt;

    // Next-state values.
    logic [4:1]              sr_next;
    logic [4:1]              rise_next;
    logic [4:1][CNT_W-1:0]   cnt_next;
    logic [4:1]              stuck_next;
    logic [4:1][STUCK_W-1:0] scnt_next;
    logic                    fault_next;

    // Debounce: SR moves only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    // Any agreeing sample restarts the count.
    always_comb begin
        sr_next  = SR;
        cnt_next = cnt;
        for (int i = 1; i <= 4; i++) begin
            if (s2[i] == SR[i]) begin
                cnt_next[i] = '0;
            end else if (cnt[i] == CNT_MAX) begin
                sr_next[i]  = s2[i];
                cnt_next[i] = '0;
            end else begin
                cnt_next[i] = cnt[i] + CNT_W'(1);
            end
        end
        rise_next = sr_next & ~SR;
    end

    // Stuck watchdog: count cycles with SR high and saturate at the terminal value.
    // A clear request beats a same-edge set.
    always_comb begin
        stuck_next = STUCK;
        scnt_next  = scnt;
        for (int i = 1; i <= 4; i++) begin
            if (CLR_STUCK) begin
                stuck_next[i] = 1'b0;
                scnt_next[i]  = '0;
            end else if (!SR[i]) begin
                scnt_next[i]  = '0;
            end else if (scnt[i] == SCNT_MAX) begin
                stuck_next[i] = 1'b1;
            end else begin
                scnt_next[i]  = scnt[i] + STUCK_W'(1);
            end
        end
        fault_next = |stuck_next;
    end

    // State register with synchronous reset. Reset wins over everything and drops
    // any debounce that is in progress.
    always_ff @(posedge Clock) begin
        if (RESET) begin
            s1      <= '0;
            s2      <= '0;
            cnt     <= '0;
            scnt    <= '0;
            SR      <= '0;
            SR_RISE <= '0;
            STUCK   <= '0;
            FAULT   <= 1'b0;
        end else begin
            s1      <= RAW_SR;
            s2      <= s1;
            cnt     <= cnt_next;
            scnt    <= scnt_next;
            SR      <= sr_next;
            SR_RISE <= rise_next;
            STUCK   <= stuck_next;
            FAULT   <= fault_next;
        end
    end

endmodule
